// File: rtl/mips_isa_pkg.sv
// MIPS I-type opcodes, field positions and constant classes.
// Shared by li_classify and li_expander; no ports.
package mips_isa_pkg;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int IMM_LSB = 0;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;

  typedef enum logic [1:0] {
    FIT_S,
    FIT_U,
    WIDE
  } li_class_e;

  function automatic logic [31:0] itype(
    input logic [OPC_W-1:0] op,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic [IMM_W-1:0] imm
  );
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = op;
    w[RS_LSB  +: REG_W] = rs;
    w[RT_LSB  +: REG_W] = rt;
    w[IMM_LSB +: IMM_W] = imm;
    return w;
  endfunction

endpackage

// File: rtl/li_expander_if.sv
// Request (in_*) and instruction-word (out_*) valid/ready bundle.
// master: request source / word sink; slave: li_expander.
interface li_expander_if;

  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rt;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  modport master (
    output in_valid,
    output in_rt,
    output in_imm,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_rt,
    input  in_imm,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_last
  );

endinterface

// File: rtl/li_classify.sv
// Combinational class of a 32-bit constant for a 16-bit immediate.
// imm_i -> cls_o (FIT_S/FIT_U/WIDE), two_o (WIDE needs trailing ORI).
module li_classify
  import mips_isa_pkg::*;
(
  input  logic [31:0] imm_i,
  output li_class_e   cls_o,
  output logic        two_o
);

  logic fit_s;
  logic fit_u;

  // Sign-extension round trip needs bits 31..15 identical.
  assign fit_s = (&imm_i[31:15]) | ~(|imm_i[31:15]);
  assign fit_u = ~fit_s & ~(|imm_i[31:16]);

  always_comb begin
    cls_o = WIDE;
    unique case (1'b1)
      fit_s:   cls_o = FIT_S;
      fit_u:   cls_o = FIT_U;
      default: cls_o = WIDE;
    endcase
  end

  assign two_o = (cls_o == WIDE) & (|imm_i[15:0]);

endmodule

// File: rtl/li_expander.sv
// Expands a load-immediate request into ADDIU, ORI, or LUI(+ORI).
// Ports: clk, reset (sync, high), bus (slave), instr_count.
module li_expander
  import mips_isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  li_expander_if.slave     bus,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT1,
    EMIT2
  } state_e;

  state_e     state_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic [31:0] out_instr_q;
  logic       out_last_q;
  logic [31:0] word2_q;
  logic [CNT_W-1:0] cnt_q;

  li_class_e  cls;
  logic       two;
  logic [31:0] word1_d;
  logic [31:0] word2_d;
  logic       last1_d;
  logic       accept;

  li_classify u_cls (
    .imm_i (bus.in_imm),
    .cls_o (cls),
    .two_o (two)
  );

  always_comb begin
    word1_d = '0;
    unique case (cls)
      FIT_S: word1_d = itype(OP_ADDIU, 5'd0,
                             bus.in_rt,
                             bus.in_imm[15:0]);
      FIT_U: word1_d = itype(OP_ORI, 5'd0,
                             bus.in_rt,
                             bus.in_imm[15:0]);
      WIDE:  word1_d = itype(OP_LUI, 5'd0,
                             bus.in_rt,
                             bus.in_imm[31:16]);
      default: word1_d = '0;
    endcase
  end

  // Second half ORs the low bits into the LUI result.
  assign word2_d = itype(OP_ORI, bus.in_rt,
                         bus.in_rt,
                         bus.in_imm[15:0]);
  assign last1_d = ~two;
  assign accept  = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
      word2_q     <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q     <= EMIT1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_instr_q <= word1_d;
            out_last_q  <= last1_d;
            word2_q     <= word2_d;
          end
        end
        EMIT1: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= EMIT2;
              out_instr_q <= word2_q;
              out_last_q  <= 1'b1;
            end
          end
        end
        EMIT2: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
      if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_last  = out_last_q;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_li_expander.sv
// Scoreboard bench for li_expander: directed requests, queue-based
// monitor on the output handshake, instr_count model.
module tb_li_expander;

  typedef struct packed {
    logic [31:0] w;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cnt;

  li_expander_if bus ();

  li_expander #(.CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .instr_count (cnt)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];
  logic [15:0] cnt_model = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("instr_count", {16'h0, cnt}, {16'h0, cnt_model});
      if (reset) begin
        q.delete();
        cnt_model = '0;
      end else if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none",
                   bus.out_instr);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word", bus.out_instr, e.w);
          chk("last", {31'h0, bus.out_last}, {31'h0, e.l});
        end
        cnt_model = cnt_model + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  // Returns #1 after the accepting edge.
  task automatic send(input logic [4:0] rt,
                      input logic [31:0] imm);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_rt    = rt;
    bus.in_imm   = imm;
    tick();
    bus.in_valid = 1'b0;
    chk("latency_valid", {31'h0, bus.out_valid}, 32'd1);
  endtask

  task automatic push(input logic [31:0] w, input logic l);
    exp_t e;
    e.w = w;
    e.l = l;
    q.push_back(e);
  endtask

  logic [15:0] c0;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_rt     = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_last", {31'h0, bus.out_last}, 32'd0);
    chk("rst_count", {16'h0, cnt}, 32'd0);
    mon_en = 1'b1;
    tick();

    push(32'h24088000, 1'b1);
    send(5'd8, 32'hFFFF8000);
    chk("addiu_busy", {31'h0, bus.in_ready}, 32'd0);
    tick();
    chk("addiu_ready_back", {31'h0, bus.in_ready}, 32'd1);
    chk("addiu_count", {16'h0, cnt}, 32'd1);

    push(32'h3409ABCD, 1'b1);
    send(5'd9, 32'h0000ABCD);
    wait_ready();

    c0 = cnt;
    push(32'h3C0A1234, 1'b0);
    push(32'h354A5678, 1'b1);
    send(5'd10, 32'h12345678);
    chk("wide_w1", bus.out_instr, 32'h3C0A1234);
    chk("wide_busy1", {31'h0, bus.in_ready}, 32'd0);
    tick();
    chk("wide_w2_valid", {31'h0, bus.out_valid}, 32'd1);
    chk("wide_w2", bus.out_instr, 32'h354A5678);
    chk("wide_busy2", {31'h0, bus.in_ready}, 32'd0);
    tick();
    chk("wide_ready_back", {31'h0, bus.in_ready}, 32'd1);
    chk("wide_count", {16'h0, cnt}, {16'h0, c0 + 16'd2});

    push(32'h3C040001, 1'b1);
    send(5'd4, 32'h00010000);
    tick();
    chk("lui_only_ready", {31'h0, bus.in_ready}, 32'd1);
    chk("lui_only_idle", {31'h0, bus.out_valid}, 32'd0);

    push(32'h24037FFF, 1'b1);
    send(5'd3, 32'h00007FFF);
    push(32'h34058000, 1'b1);
    send(5'd5, 32'h00008000);
    push(32'h3C02FFFF, 1'b0);
    push(32'h34427FFF, 1'b1);
    send(5'd2, 32'hFFFF7FFF);
    wait_ready();

    c0 = cnt;
    bus.out_ready = 1'b0;
    push(32'h3C0A1234, 1'b0);
    push(32'h354A5678, 1'b1);
    send(5'd10, 32'h12345678);
    bus.in_valid = 1'b1;
    bus.in_rt    = 5'd1;
    bus.in_imm   = 32'h00000005;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_instr", bus.out_instr, 32'h3C0A1234);
      chk("hold_last", {31'h0, bus.out_last}, 32'd0);
      chk("hold_busy", {31'h0, bus.in_ready}, 32'd0);
      chk("hold_count", {16'h0, cnt}, {16'h0, c0});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_ready();

    push(32'h3C0A1234, 1'b0);
    send(5'd10, 32'h12345678);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("mid_rst_ready", {31'h0, bus.in_ready}, 32'd1);
    chk("mid_rst_count", {16'h0, cnt}, 32'd0);
    for (int i = 0; i < 4; i++) tick();

    push(32'h24088000, 1'b1);
    send(5'd8, 32'hFFFF8000);
    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
        tick();
        n++;
      end
    end
    tick();
    chk("queue_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/li_expander.md
# li_expander

Expands a "load 32-bit immediate" request into one or two MIPS I-type instruction words. It is the reverse direction of the datapath's 16→32 sign-extension: it decides whether a 32-bit constant survives a round trip through a 16-bit immediate field, and splits it into LUI/ORI halves when it does not. It sits in the test-program loader path, between the constant request source and the instruction-memory writer. Handshakes are valid/ready on both sides, and each output word is held until it is accepted.

## Interface
Parameters:
- CNT_W, 16, width of the emitted-instruction counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_rt  input  5  destination register number
- in_imm  input  32  constant to load
- out_valid  output  1  out_instr holds a valid word
- out_ready  input  1  downstream accepts out_instr
- out_instr  output  32  encoded I-type word: opcode[31:26] rs[25:21] rt[20:16] imm[15:0]
- out_last  output  1  marks the final word of the current expansion
- instr_count  output  CNT_W  total words accepted downstream since reset, wraps modulo 2^CNT_W

## Operation
- Classification at acceptance:
  - FIT_S: in_imm[31:15] is all 0s or all 1s. Emit ADDIU rt,$0,imm[15:0] (opcode 6'h09, rs=0). One word.
  - FIT_U: not FIT_S, and in_imm[31:16]==0. Emit ORI rt,$0,imm[15:0] (opcode 6'h0D, rs=0). One word.
  - WIDE: otherwise, emit LUI rt,imm[31:16] (opcode 6'h0F, rs=0).
    - If imm[15:0]!=0, follow with ORI rt,rt,imm[15:0] (rs=rt).
    - If imm[15:0]==0, the LUI is the only word.
- FIT_S takes priority over FIT_U. Example: 0x00007FFF uses ADDIU.
- rt=0 is not special-cased; words are emitted normally.
- State machine:
  - IDLE → EMIT1 on in_valid (request latched).
  - EMIT1 → IDLE when the word is accepted and out_last=1.
  - EMIT1 → EMIT2 when the word is accepted and out_last=0.
  - EMIT2 → IDLE when the word is accepted.
- in_ready=1 only in IDLE. There is no back-to-back overlap: one request is in flight at a time.
- A word is "accepted" on any cycle with out_valid & out_ready. instr_count increments by 1 on each acceptance.
- While out_valid=1 and out_ready=0, out_instr and out_last are held stable.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_last=0, instr_count=0, state IDLE.
- Reset mid-expansion (EMIT1 or EMIT2) discards the request. No partial word is emitted afterward.
- Latency: request accepted at edge N gives out_valid=1 with the first word after edge N.
- The second word (WIDE case) is presented in the cycle after the first word is accepted. There are no bubbles beyond that.
- With out_ready held at 1: a single-word request occupies 1 cycle in EMIT1; a two-word request occupies 2 cycles.
- in_ready returns to 1 in the cycle after the final acceptance.
- in_valid while in_ready=0 is ignored. The source must hold the request until in_ready=1.
- Outputs are registered. There is no combinational path from in_* or out_ready to out_instr.

## Structure
- A shared package mips_isa_pkg holds:
  - OP_ADDIU, OP_ORI, OP_LUI opcode constants.
  - The I-type field positions.
  - An enum for the classes FIT_S/FIT_U/WIDE.
- Sub-module li_classify is purely combinational: in_imm → class, plus a flag for the second word.
- The top level holds the FSM, the request/output registers and the counter.

## Test plan
- rt=8, imm=0xFFFF8000 → one word, 0x24088000, out_last=1; instr_count=1.
- rt=9, imm=0x0000ABCD → one word, 0x3409ABCD, out_last=1.
- rt=10, imm=0x12345678 → two words on consecutive cycles:
  - 0x3C0A1234 with last=0;
  - then 0x354A5678 with last=1;
  - in_ready=0 throughout, instr_count advances by 2.
- rt=4, imm=0x00010000 → one word, 0x3C040001, last=1. No ORI follows.
- Hold out_ready=0 for 3 cycles during a WIDE expansion:
  - out_instr stays 0x3C0A1234;
  - instr_count is unchanged;
  - a second in_valid during this time is not accepted.
- Assert reset in the cycle after the LUI of 0x12345678 is accepted:
  - next cycle out_valid=0, in_ready=1, instr_count=0;
  - no ORI word appears.
